// File: rtl/bm_free_buf_pool.sv
// Free-buffer pointer pool: circular pointer FIFO with per-port in-use counts, self-filled after reset.
// Alloc ack is 2 cycles after grant with back-to-back grants; releases have no backpressure and illegal ones pulse rel_err.
module bm_free_buf_pool #(
   parameter int BUF_PTR_NBITS = 10,
   parameter int PORT_ID_NBITS = 3,
   parameter int NUM_PORTS     = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   rel_buf_valid,
   input  logic [PORT_ID_NBITS-1:0]               rel_buf_port_id,
   input  logic [BUF_PTR_NBITS-1:0]               rel_buf_ptr,
   input  logic                                   alloc_req,
   input  logic [PORT_ID_NBITS-1:0]               alloc_port_id,
   output logic                                   alloc_ack,
   output logic [BUF_PTR_NBITS-1:0]               alloc_buf_ptr,
   output logic                                   init_read_count_valid,
   output logic [BUF_PTR_NBITS-1:0]               init_read_count_ptr,
   output logic                                   init_done,
   output logic [BUF_PTR_NBITS:0]                 free_count,
   output logic [NUM_PORTS*(BUF_PTR_NBITS+1)-1:0] port_buf_cnt,
   output logic                                   rel_err
);
   localparam int DEPTH = 1 << BUF_PTR_NBITS;
   localparam int CW    = BUF_PTR_NBITS + 1;
   localparam int SW    = BUF_PTR_NBITS + PORT_ID_NBITS + 2;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [BUF_PTR_NBITS-1:0] ram_q [DEPTH];
   logic [0:0]               state_q, state_d;
   logic [BUF_PTR_NBITS-1:0] hd_q, hd_d, tl_q, tl_d;
   logic [CW-1:0]            free_q, free_d;
   logic [CW-1:0]            cnt_q [NUM_PORTS];
   logic [CW-1:0]            cnt_d [NUM_PORTS];
   logic [CW-1:0]            rel_cnt;
   logic [SW-1:0]            cnt_sum;
   logic                     run, gnt, rel_ok, rel_bad;
   logic                     ram_we;
   logic [BUF_PTR_NBITS-1:0] ram_wd, rd_dat_q;
   logic                     gnt_p1_q, ack_q, irc_vld_q, rel_err_q;
   logic [BUF_PTR_NBITS-1:0] ack_ptr_q, irc_ptr_q;

   always_comb begin
      run     = (state_q == ST_RUN);
      rel_cnt = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rel_buf_port_id == PORT_ID_NBITS'(p)) rel_cnt = cnt_q[p];
      end
      // Legality uses start-of-cycle counts only: a same-cycle release never enables a grant.
      gnt     = run && alloc_req && (free_q != '0);
      rel_ok  = run && rel_buf_valid && (free_q != CW'(DEPTH)) && (rel_cnt != '0);
      rel_bad = run && rel_buf_valid && !rel_ok;
   end

   always_comb begin
      state_d = state_q;
      hd_d    = hd_q;
      tl_d    = tl_q;
      free_d  = free_q;
      cnt_d   = cnt_q;
      ram_we  = 1'b0;
      ram_wd  = rel_buf_ptr;
      if (!run) begin
         ram_we = 1'b1;
         ram_wd = tl_q;
         tl_d   = tl_q + 1'b1;
         free_d = free_q + 1'b1;
         if (tl_q == BUF_PTR_NBITS'(DEPTH - 1)) state_d = ST_RUN;
      end else begin
         if (gnt) hd_d = hd_q + 1'b1;
         if (rel_ok) begin
            ram_we = 1'b1;
            tl_d   = tl_q + 1'b1;
         end
         case ({gnt, rel_ok})
            2'b10:   free_d = free_q - 1'b1;
            2'b01:   free_d = free_q + 1'b1;
            default: free_d = free_q;
         endcase
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt && alloc_port_id == PORT_ID_NBITS'(p))     cnt_d[p] = cnt_d[p] + 1'b1;
            if (rel_ok && rel_buf_port_id == PORT_ID_NBITS'(p)) cnt_d[p] = cnt_d[p] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         hd_q      <= '0;
         tl_q      <= '0;
         free_q    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
         gnt_p1_q  <= 1'b0;
         ack_q     <= 1'b0;
         ack_ptr_q <= '0;
         irc_vld_q <= 1'b0;
         irc_ptr_q <= '0;
         rel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hd_q      <= hd_d;
         tl_q      <= tl_d;
         free_q    <= free_d;
         cnt_q     <= cnt_d;
         gnt_p1_q  <= gnt;
         ack_q     <= gnt_p1_q;
         if (gnt_p1_q) ack_ptr_q <= rd_dat_q;
         irc_vld_q <= !run;
         if (!run) irc_ptr_q <= tl_q;
         rel_err_q <= rel_bad;
      end
   end

   // Read and write slots never collide: a grant implies hd points at a filled entry, tl at an empty one.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[tl_q] <= ram_wd;
      rd_dat_q <= ram_q[hd_q];
   end

   always_comb begin
      cnt_sum = '0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_sum = cnt_sum + SW'(cnt_q[p]);
   end

   assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_RUN) |-> (SW'(free_q) + cnt_sum == SW'(DEPTH)));

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
      assign port_buf_cnt[g*CW +: CW] = cnt_q[g];
   end

   assign alloc_ack             = ack_q;
   assign alloc_buf_ptr         = ack_ptr_q;
   assign init_read_count_valid = irc_vld_q;
   assign init_read_count_ptr   = irc_ptr_q;
   assign init_done             = state_q;
   assign free_count            = free_q;
   assign rel_err               = rel_err_q;
endmodule

// File: tb/tb_bm_free_buf_pool.sv
// Bench for bm_free_buf_pool: free-list/port-count model predicts acks and rel_err pulses into scoreboard queues.
module tb_bm_free_buf_pool;
   localparam int PW    = 4;
   localparam int IW    = 3;
   localparam int NP    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = PW + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             rel_buf_valid;
   logic [IW-1:0]    rel_buf_port_id;
   logic [PW-1:0]    rel_buf_ptr;
   logic             alloc_req;
   logic [IW-1:0]    alloc_port_id;
   logic             alloc_ack;
   logic [PW-1:0]    alloc_buf_ptr;
   logic             init_read_count_valid;
   logic [PW-1:0]    init_read_count_ptr;
   logic             init_done;
   logic [PW:0]      free_count;
   logic [NP*CW-1:0] port_buf_cnt;
   logic             rel_err;

   bm_free_buf_pool #(.BUF_PTR_NBITS(PW), .PORT_ID_NBITS(IW), .NUM_PORTS(NP)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .rel_buf_valid         (rel_buf_valid),
      .rel_buf_port_id       (rel_buf_port_id),
      .rel_buf_ptr           (rel_buf_ptr),
      .alloc_req             (alloc_req),
      .alloc_port_id         (alloc_port_id),
      .alloc_ack             (alloc_ack),
      .alloc_buf_ptr         (alloc_buf_ptr),
      .init_read_count_valid (init_read_count_valid),
      .init_read_count_ptr   (init_read_count_ptr),
      .init_done             (init_done),
      .free_count            (free_count),
      .port_buf_cnt          (port_buf_cnt),
      .rel_err               (rel_err)
   );

   always #5 clk = ~clk;

   typedef struct { int c; int v; } exp_t;
   exp_t ack_q[$];
   int   err_q[$];
   int   m_free[$];
   int   m_cnt[NP];
   bit   m_run;
   int   cyc;
   int   n_vec;
   int   n_mis;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [NP*CW-1:0] pack_cnt();
      logic [NP*CW-1:0] r;
      for (int p = 0; p < NP; p++) r[p*CW +: CW] = CW'(m_cnt[p]);
      return r;
   endfunction

   // Drive one cycle; the model is advanced with start-of-cycle state.
   task automatic drive(bit req, int ap, bit rv, int rp, int rptr);
      bit   g, ok;
      exp_t e;
      alloc_req       = req;
      alloc_port_id   = IW'(ap);
      rel_buf_valid   = rv;
      rel_buf_port_id = IW'(rp);
      rel_buf_ptr     = PW'(rptr);
      g  = m_run && req && (m_free.size() != 0);
      ok = m_run && rv && (m_free.size() != DEPTH) && (m_cnt[rp] != 0);
      if (m_run && rv && !ok) err_q.push_back(cyc + 1);
      if (g) begin
         e.c = cyc + 2;
         e.v = m_free.pop_front();
         ack_q.push_back(e);
         m_cnt[ap]++;
      end
      if (ok) begin
         m_free.push_back(rptr);
         m_cnt[rp]--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0);
   endtask

   task automatic check_state(string tag, int exp_free);
      check_eq({tag, "_free"}, free_count, exp_free);
      check_eq({tag, "_free_model"}, free_count, m_free.size());
      check_eq({tag, "_cnt"}, port_buf_cnt, pack_cnt());
   endtask

   task automatic do_reset(bit busy);
      exp_t keep_a[$];
      int   keep_e[$];
      // Outputs landing in this cycle are still produced; later ones are flushed by reset.
      foreach (ack_q[k]) if (ack_q[k].c <= cyc) keep_a.push_back(ack_q[k]);
      foreach (err_q[k]) if (err_q[k] <= cyc) keep_e.push_back(err_q[k]);
      ack_q = keep_a;
      err_q = keep_e;
      m_run = 0;
      m_free.delete();
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      rst             = 1'b1;
      alloc_req       = busy;
      alloc_port_id   = 3'd5;
      rel_buf_valid   = busy;
      rel_buf_port_id = 3'd5;
      rel_buf_ptr     = 4'd9;
      @(posedge clk);
      #1;
      check_eq("rst_ack", alloc_ack, 0);
      check_eq("rst_ack_ptr", alloc_buf_ptr, 0);
      check_eq("rst_free", free_count, 0);
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_irc_vld", init_read_count_valid, 0);
      check_eq("rst_irc_ptr", init_read_count_ptr, 0);
      check_eq("rst_rel_err", rel_err, 0);
      check_eq("rst_cnt", port_buf_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         @(posedge clk);
         #1;
         check_eq("init_vld", init_read_count_valid, 1);
         check_eq("init_ptr", init_read_count_ptr, j);
         check_eq("init_free", free_count, j + 1);
         check_eq("init_done", init_done, (j == DEPTH - 1));
         check_eq("init_cnt", port_buf_cnt, 0);
         if (j == DEPTH - 1) begin
            alloc_req     = 1'b0;
            rel_buf_valid = 1'b0;
         end
      end
      for (int k = 0; k < DEPTH; k++) m_free.push_back(k);
      m_run = 1;
      idle(1);
      check_eq("post_init_vld", init_read_count_valid, 0);
      check_eq("post_init_done", init_done, 1);
      check_state("post_init", DEPTH);
   endtask

   always @(negedge clk) begin
      if (ack_q.size() != 0 && ack_q[0].c == cyc) begin
         check_eq("ack_vld", alloc_ack, 1);
         check_eq("ack_ptr", alloc_buf_ptr, ack_q[0].v);
         void'(ack_q.pop_front());
      end else if (alloc_ack !== 1'b0) begin
         check_eq("ack_spurious", alloc_ack, 0);
      end
      if (err_q.size() != 0 && err_q[0] == cyc) begin
         check_eq("rel_err_vld", rel_err, 1);
         void'(err_q.pop_front());
      end else if (rel_err !== 1'b0 && !rst) begin
         check_eq("rel_err_spurious", rel_err, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_mis = 0;
      do_reset(0);

      // Release into a full pool is illegal.
      drive(0, 0, 1, 0, 3);
      idle(2);
      check_state("full_rel", DEPTH);

      // Drain the pool on port 2; the 17th request must not be granted.
      for (int i = 0; i < DEPTH; i++) drive(1, 2, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      idle(3);
      check_state("drain", 0);
      check_eq("drain_cnt2", port_buf_cnt[2*CW +: CW], DEPTH);

      // Released pointers come back in FIFO order across the wrap.
      drive(0, 0, 1, 2, 5);
      drive(0, 0, 1, 2, 3);
      drive(1, 2, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      idle(3);
      check_state("wrap", 0);

      // Release from a port holding nothing.
      drive(0, 0, 1, 4, 7);
      idle(2);
      check_state("bad_port", 0);

      // Bring free_count to 8 with port 1 holding one buffer.
      for (int p = 8; p < 16; p++) drive(0, 0, 1, 2, p);
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 1, 2, 0);
      idle(3);
      check_state("pre_sim", 8);

      drive(1, 1, 1, 1, 8);
      idle(3);
      check_state("sim_same", 8);
      check_eq("sim_same_cnt1", port_buf_cnt[1*CW +: CW], 1);

      drive(1, 3, 1, 2, 1);
      idle(3);
      check_state("sim_diff", 8);

      // Reset with acks in flight and traffic held through the fill.
      drive(1, 5, 0, 0, 0);
      drive(1, 5, 0, 0, 0);
      do_reset(1);
      for (int i = 0; i < 3; i++) drive(1, 6, 0, 0, 0);
      idle(3);
      check_state("after_rerst", DEPTH - 3);

      check_eq("ack_q_drained", ack_q.size(), 0);
      check_eq("err_q_drained", err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/bm_free_buf_pool.md
Name: bm_free_buf_pool

Overview:
- Free-buffer pointer pool for the buffer manager. Sits directly downstream of bm_buf_release and consumes its rel_buf_valid/rel_buf_port_id/rel_buf_ptr stream.
- Hands out free buffer pointers to the ingress writer over an alloc request/ack interface and keeps per-port in-use counts.
- After reset, fills the pool with every pointer. During that fill it drives init_read_count_valid/init_read_count_ptr, which bm_buf_release uses to zero its release counters.

Parameters:
BUF_PTR_NBITS, 10, pointer width; pool depth DEPTH = 2**BUF_PTR_NBITS
PORT_ID_NBITS, 3, port id width
NUM_PORTS, 8, number of ports tracked (at most 2**PORT_ID_NBITS)

Ports:
clk  in  1  clock
rst  in  1  reset (the RESET_SIG port); synchronous, active-high
rel_buf_valid  in  1  release strobe from bm_buf_release; no backpressure
rel_buf_port_id  in  PORT_ID_NBITS  port owning the released buffer
rel_buf_ptr  in  BUF_PTR_NBITS  released pointer
alloc_req  in  1  level request for one buffer
alloc_port_id  in  PORT_ID_NBITS  port requesting the buffer
alloc_ack  out  1  one-cycle strobe: alloc_buf_ptr is valid
alloc_buf_ptr  out  BUF_PTR_NBITS  allocated pointer
init_read_count_valid  out  1  init strobe to bm_buf_release
init_read_count_ptr  out  BUF_PTR_NBITS  pointer being initialised
init_done  out  1  pool is ready
free_count  out  BUF_PTR_NBITS+1  number of free pointers
port_buf_cnt  out  NUM_PORTS*(BUF_PTR_NBITS+1)  per-port in-use count, port 0 in the LSBs
rel_err  out  1  one-cycle strobe: illegal release dropped

Behaviour:
- Storage: a DEPTH-entry pointer RAM used as a circular FIFO.
  - Head pointer hd and tail pointer tl, both BUF_PTR_NBITS wide, wrapping naturally modulo DEPTH.
  - RAM read latency is 1 cycle.
- State machine has two states, INIT and RUN.
  - rst forces INIT from any state, including mid-operation. In-flight acks are discarded and the fill restarts at 0.
- Reset values: hd=0, tl=0, free_count=0, all port_buf_cnt=0, alloc_ack=0, alloc_buf_ptr=0, init_read_count_valid=0, init_read_count_ptr=0, init_done=0, rel_err=0.
- INIT:
  - Counter i runs 0..DEPTH-1, one step per cycle. Each cycle writes ram[i]=i and drives init_read_count_valid=1 with init_read_count_ptr=i (registered).
  - free_count increments by 1 per cycle. tl advances with i.
  - After i=DEPTH-1 is written, the next cycle is RUN with init_done=1, free_count=DEPTH and tl=0 (wrapped).
  - Releases and alloc_req are ignored in INIT; no ack and no rel_err are produced.
- RUN, alloc:
  - A grant occurs in cycle T when alloc_req=1 and free_count!=0 (value at the start of T).
  - On grant: read ram[hd], hd<=hd+1, free_count decrements, and port_buf_cnt[alloc_port_id] increments.
  - alloc_ack=1 at T+2, with alloc_buf_ptr = the pointer read.
  - One grant per cycle is allowed back-to-back, so a sustained request gives a continuous ack stream 2 cycles behind.
  - free_count==0 means no grant, and alloc_req is held without an ack.
  - A release in the same cycle never enables a grant (no bypass).
- RUN, release: when rel_buf_valid=1:
  - If free_count==DEPTH, or port_buf_cnt[rel_buf_port_id]==0, the release is dropped and rel_err=1 next cycle. Nothing changes.
  - Otherwise: ram[tl]<=rel_buf_ptr, tl<=tl+1, free_count increments, and port_buf_cnt[rel_buf_port_id] decrements.
- Simultaneous grant and legal release in the same cycle:
  - free_count is unchanged.
  - Both port counters update. If it is the same port, that counter is unchanged.
  - The RAM read and write addresses are guaranteed to differ: a grant needs free_count>0, and the write slot tl is empty.
- Counter ranges: free_count stays within 0..DEPTH, and no port counter exceeds DEPTH.
- Pointers are not checked for duplicates; bm_buf_release guarantees uniqueness.
- Invariant (checked by assertion): free_count + sum(port_buf_cnt) == DEPTH in RUN.

Test Plan:
(Bench uses BUF_PTR_NBITS=4, so DEPTH=16.)
1. Reset, then run -> init_read_count_valid high for 16 consecutive cycles with ptr 0..15; init_done rises on the 17th cycle; free_count=16.
2. alloc_req held for 16 cycles with port 2 -> alloc_ack on 16 consecutive cycles starting 2 cycles after the first grant, ptrs 0..15; free_count=0; port_buf_cnt[2]=16; a 17th request gets no ack.
3. Release ptrs 5, 3 for port 2, then alloc twice -> acks return 5 then 3; hd and tl have wrapped past 15 to 0..2.
4. Release ptr 7 for port 4 while port_buf_cnt[4]=0 -> rel_err pulses 1 cycle later; free_count and counters unchanged.
5. Same-cycle grant (port 1) and legal release (port 1) at free_count=8 -> free_count stays 8; port_buf_cnt[1] unchanged; ack 2 cycles later.
6. Assert rst mid-stream with acks in flight -> no ack after reset; full 16-cycle INIT repeats; counters are 0 until the fill completes.
